// File: rtl/multiport_register_file.sv
// ---------------------------------------------------------------------------
// multiport_register_file
//
// Purpose:
//   Parametrised register file for the processor datapath. It provides NRD
//   combinational read ports and two synchronous write lanes. A per-register
//   busy scoreboard supports issue-stage hazard checks. Decode drives the read
//   addresses and issue marks. Writeback drives the two retire lanes.
//
// Parameters:
//   DATA_W    register width in bits
//   ADDR_W    address width; depth = 2**ADDR_W
//   NRD       number of read ports (>= 1)
//   ZERO_REG  1: register 0 reads 0, ignores writes and is never busy
//
// Ports:
//   clk       clock; all state updates on the rising edge
//   n_rst     asynchronous active-low reset
//   ra        read addresses, port k = ra[k*ADDR_W +: ADDR_W]
//   rd        read data,      port k = rd[k*DATA_W +: DATA_W]
//   rbusy     busy bit of the register addressed by port k
//   we0/wa0/wd0  write lane 0
//   we1/wa1/wd1  write lane 1 (wins on same-address collision)
//   iss_en    mark register iss_addr busy (producer issued)
//   iss_addr  register to mark busy
//
// Configuration macro:
//   RF_BYPASS_EN  when defined, the read ports forward same-cycle write data.
//                 An address that is being written reads as not busy, unless
//                 it is also being issued in the same cycle.
//                 When undefined, reads reflect only the stored state.
// ---------------------------------------------------------------------------
module multiport_register_file #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 3,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 0
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic [NRD*ADDR_W-1:0]   ra,
    output logic [NRD*DATA_W-1:0]   rd,
    output logic [NRD-1:0]          rbusy,
    input  logic                    we0,
    input  logic [ADDR_W-1:0]       wa0,
    input  logic [DATA_W-1:0]       wd0,
    input  logic                    we1,
    input  logic [ADDR_W-1:0]       wa1,
    input  logic [DATA_W-1:0]       wd1,
    input  logic                    iss_en,
    input  logic [ADDR_W-1:0]       iss_addr
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_busy;

    // Effective enables. When ZERO_REG is set, any operation that targets
    // register 0 is suppressed here. The other lane is not affected.
    logic w_we0;
    logic w_we1;
    logic w_iss;

    assign w_we0 = we0    && !((ZERO_REG != 0) && (wa0 == '0));
    assign w_we1 = we1    && !((ZERO_REG != 0) && (wa1 == '0));
    assign w_iss = iss_en && !((ZERO_REG != 0) && (iss_addr == '0));

    // NOTE: the storage array is reset like ordinary flops. Reset must return
    // every register to 0, so this file cannot map onto a RAM macro that has
    // no reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            // NOTE: both lanes use non-blocking assignments to the same array.
            // When the addresses collide, the later statement takes effect,
            // so lane 1 is deliberately written second.
            if (w_we0) r_regs[wa0] <= wd0;
            if (w_we1) r_regs[wa1] <= wd1;

            // A newly issued producer supersedes a retiring write to the
            // same register, so the set takes priority over the clear.
            for (int i = 0; i < DEPTH; i++) begin
                if (w_iss && (iss_addr == ADDR_W'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if ((w_we0 && (wa0 == ADDR_W'(i))) ||
                             (w_we1 && (wa1 == ADDR_W'(i)))) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    // Read ports: combinational; any port may alias any other port.
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_bsy;

    // NOTE: every variable that this block writes receives a default value
    // before the loop. This prevents a latch from being inferred.
    always_comb begin
        rd     = '0;
        rbusy  = '0;
        w_addr = '0;
        w_data = '0;
        w_bsy  = 1'b0;
        for (int k = 0; k < NRD; k++) begin
            w_addr = ra[k*ADDR_W +: ADDR_W];
            w_data = r_regs[w_addr];
            w_bsy  = r_busy[w_addr];
`ifdef RF_BYPASS_EN
            // Forwarding is disabled while reset is asserted, so the read
            // ports return 0 immediately.
            if (n_rst && w_we1 && (wa1 == w_addr)) begin
                w_data = wd1;
                w_bsy  = (w_iss && (iss_addr == w_addr)) ? r_busy[w_addr] : 1'b0;
            end else if (n_rst && w_we0 && (wa0 == w_addr)) begin
                w_data = wd0;
                w_bsy  = (w_iss && (iss_addr == w_addr)) ? r_busy[w_addr] : 1'b0;
            end
`endif
            if ((ZERO_REG != 0) && (w_addr == '0)) begin
                w_data = '0;
                w_bsy  = 1'b0;
            end
            rd[k*DATA_W +: DATA_W] = w_data;
            rbusy[k]               = w_bsy;
        end
    end

endmodule

// File: tb/tb_multiport_register_file.sv
// ---------------------------------------------------------------------------
// tb_multiport_register_file
//
// Directed bench for multiport_register_file, using the default geometry:
// 32-bit data, 8 registers and 2 read ports.
//   dut   : ZERO_REG = 0
//   dut_z : ZERO_REG = 1; shares all inputs with dut
//
// Each row of the vector table applies one set of inputs across one rising
// edge. The write and issue inputs are then dropped, and both read ports are
// compared against the expected post-edge values. Hand-written sequences
// cover reset, the write-cycle read, ZERO_REG and an asynchronous reset that
// is asserted partway through a cycle.
// ---------------------------------------------------------------------------
module tb_multiport_register_file;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;
    localparam int NRD    = 2;

    logic                  clk = 1'b0;
    logic                  n_rst;
    logic [NRD*ADDR_W-1:0] ra;
    logic [NRD*DATA_W-1:0] rd, rd_z;
    logic [NRD-1:0]        rbusy, rbusy_z;
    logic                  we0, we1, iss_en;
    logic [ADDR_W-1:0]     wa0, wa1, iss_addr;
    logic [DATA_W-1:0]     wd0, wd1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    multiport_register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD), .ZERO_REG(0)) dut (
        .clk(clk), .n_rst(n_rst), .ra(ra), .rd(rd), .rbusy(rbusy),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss_en(iss_en), .iss_addr(iss_addr)
    );

    multiport_register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD), .ZERO_REG(1)) dut_z (
        .clk(clk), .n_rst(n_rst), .ra(ra), .rd(rd_z), .rbusy(rbusy_z),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss_en(iss_en), .iss_addr(iss_addr)
    );

    typedef struct {
        logic              we0;
        logic [ADDR_W-1:0] wa0;
        logic [DATA_W-1:0] wd0;
        logic              we1;
        logic [ADDR_W-1:0] wa1;
        logic [DATA_W-1:0] wd1;
        logic              iss_en;
        logic [ADDR_W-1:0] iss_addr;
        logic [ADDR_W-1:0] ra0;
        logic [ADDR_W-1:0] ra1;
        logic [DATA_W-1:0] exp_rd0;
        logic [DATA_W-1:0] exp_rd1;
        logic [1:0]        exp_busy;  // {port1, port0}
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic idle_inputs();
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        iss_en = 1'b0; iss_addr = '0;
    endtask

    initial begin
        // Register state is tracked by hand, row by row:
        // Columns: we0 wa0 wd0 | we1 wa1 wd1 | iss addr | ra0 ra1 | rd0 rd1 busy
        vecs[0] = '{1'b1, 3'd0, 32'h1,        1'b0, 3'd0, 32'h0,    1'b0, 3'd0, 3'd0, 3'd0, 32'h1,    32'h1,        2'b00};
        vecs[1] = '{1'b1, 3'd1, 32'hFFFFFFFF, 1'b0, 3'd0, 32'h0,    1'b0, 3'd0, 3'd0, 3'd1, 32'h1,    32'hFFFFFFFF, 2'b00};
        vecs[2] = '{1'b1, 3'd3, 32'hAAAA,     1'b1, 3'd3, 32'h5555, 1'b0, 3'd0, 3'd3, 3'd3, 32'h5555, 32'h5555,     2'b00};
        vecs[3] = '{1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0,    1'b1, 3'd4, 3'd4, 3'd3, 32'h0,    32'h5555,     2'b01};
        vecs[4] = '{1'b0, 3'd0, 32'h0,        1'b1, 3'd4, 32'h44,   1'b0, 3'd0, 3'd4, 3'd0, 32'h44,   32'h1,        2'b00};
        vecs[5] = '{1'b1, 3'd4, 32'h66,       1'b0, 3'd0, 32'h0,    1'b1, 3'd4, 3'd4, 3'd4, 32'h66,   32'h66,       2'b11};
        vecs[6] = '{1'b0, 3'd0, 32'h0,        1'b1, 3'd2, 32'h22,   1'b1, 3'd6, 3'd6, 3'd2, 32'h0,    32'h22,       2'b01};
        vecs[7] = '{1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0,    1'b1, 3'd6, 3'd6, 3'd4, 32'h0,    32'h66,       2'b11};
        vecs[8] = '{1'b1, 3'd6, 32'h7,        1'b1, 3'd4, 32'h8,    1'b0, 3'd0, 3'd6, 3'd4, 32'h7,    32'h8,        2'b00};
        vecs[9] = '{1'b1, 3'd7, 32'h11,       1'b1, 3'd5, 32'h12,   1'b0, 3'd0, 3'd7, 3'd5, 32'h11,   32'h12,       2'b00};

        // Reset sequence: a write is held active throughout reset and must
        // be discarded.
        idle_inputs();
        n_rst = 1'b0;
        we0 = 1'b1; wa0 = 3'd2; wd0 = 32'd5;
        ra = {3'd2, 3'd2};
        #100;
        check("reset_hold_rd", {32'h0, rd}, {32'h0, 64'h0});
        @(negedge clk);
        n_rst = 1'b1;
        idle_inputs();
        #1;
        check("reset_rd_reg2",  {32'h0, rd},    64'h0);
        check("reset_rbusy",    {62'h0, rbusy}, 64'h0);
        ra = {3'd7, 3'd5};
        #1;
        check("reset_rd_other", {32'h0, rd},    64'h0);

        // Apply the vector table.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            we0 = vecs[i].we0; wa0 = vecs[i].wa0; wd0 = vecs[i].wd0;
            we1 = vecs[i].we1; wa1 = vecs[i].wa1; wd1 = vecs[i].wd1;
            iss_en = vecs[i].iss_en; iss_addr = vecs[i].iss_addr;
            ra = {vecs[i].ra1, vecs[i].ra0};
            @(posedge clk);
            #1;
            idle_inputs();
            #1;
            check($sformatf("vec%0d_rd0", i),   {32'h0, rd[DATA_W-1:0]},      {32'h0, vecs[i].exp_rd0});
            check($sformatf("vec%0d_rd1", i),   {32'h0, rd[2*DATA_W-1:DATA_W]}, {32'h0, vecs[i].exp_rd1});
            check($sformatf("vec%0d_busy", i),  {62'h0, rbusy},               {62'h0, vecs[i].exp_busy});
        end

        // Read during the write cycle. Stored reg1 = FFFFFFFF.
        @(negedge clk);
        we0 = 1'b1; wa0 = 3'd1; wd0 = 32'h123;
        ra = {3'd1, 3'd1};
        #1;
`ifdef RF_BYPASS_EN
        check("write_cycle_rd", {32'h0, rd[DATA_W-1:0]}, {32'h0, 32'h123});
`else
        check("write_cycle_rd", {32'h0, rd[DATA_W-1:0]}, {32'h0, 32'hFFFFFFFF});
`endif
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        check("write_after_rd", {32'h0, rd[DATA_W-1:0]}, {32'h0, 32'h123});

        // ZERO_REG sequence: lane 0 and the issue mark target register 0,
        // while lane 1 writes register 1.
        @(negedge clk);
        we0 = 1'b1; wa0 = 3'd0; wd0 = 32'd7;
        we1 = 1'b1; wa1 = 3'd1; wd1 = 32'd9;
        iss_en = 1'b1; iss_addr = 3'd0;
        ra = {3'd1, 3'd0};
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        check("zreg_rd0",     {32'h0, rd_z[DATA_W-1:0]},        64'h0);
        check("zreg_rbusy0",  {63'h0, rbusy_z[0]},              64'h0);
        check("zreg_rd1",     {32'h0, rd_z[2*DATA_W-1:DATA_W]}, 64'd9);
        check("nozreg_rd0",   {32'h0, rd[DATA_W-1:0]},          64'd7);
        check("nozreg_busy0", {63'h0, rbusy[0]},                64'h1);

        // Reset asserted partway through a write cycle to reg5, which holds
        // 0x12. The read must drop to 0 immediately, and reg5 must stay 0
        // after reset is released.
        @(negedge clk);
        we0 = 1'b1; wa0 = 3'd5; wd0 = 32'd9;
        ra = {3'd0, 3'd5};
        #1;
`ifdef RF_BYPASS_EN
        check("midrst_pre_rd", {32'h0, rd[DATA_W-1:0]}, 64'd9);
`else
        check("midrst_pre_rd", {32'h0, rd[DATA_W-1:0]}, 64'h12);
`endif
        #1;
        n_rst = 1'b0;
        #1;
        check("midrst_rd_now",  {32'h0, rd[DATA_W-1:0]}, 64'h0);
        check("midrst_busy",    {62'h0, rbusy},          64'h0);
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        n_rst = 1'b1;
        #1;
        check("midrst_reg5",    {32'h0, rd[DATA_W-1:0]}, 64'h0);
        check("midrst_reg0",    {32'h0, rd[2*DATA_W-1:DATA_W]}, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Watchdog: this block can only fire if the stimulus never completes.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
